hazard_branch_ctrl: RTL and testbench
=====================================

Name: hazard_branch_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Resolves taken branches from the EX-stage Branch & Zero qualification and drives PC source select.
- Inserts load-use stalls, flushes wrong-path instructions, and keeps saturating event counters for the debug display.
- Sits beside the main control unit; drives PC, IF/ID and ID/EX register enables and flushes.

Parameters:
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..3).
- FLUSH_CYCLES, 2, cycles the flush signals stay asserted after a taken branch (legal 1..3).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Branch_EX  input  1  branch instruction in EX.
- Zero_EX  input  1  ALU zero flag in EX.
- Jump_ID  input  1  jump decoded in ID.
- MemRead_EX  input  1  load in EX.
- Rt_EX  input  5  load destination register in EX.
- Rs_ID  input  5  source register Rs in ID.
- Rt_ID  input  5  source register Rt in ID.
- UsesRt_ID  input  1  ID instruction reads Rt.
- PCWrite  output  1  PC register enable.
- IFIDWrite  output  1  IF/ID register enable.
- IFIDFlush  output  1  zero the IF/ID register.
- IDEXFlush  output  1  zero the ID/EX control fields.
- PCSrc  output  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 unused.
- StallCount  output  CNT_W  load-use events, saturating.
- FlushCount  output  CNT_W  taken branches plus jumps, saturating.

Behaviour:
- Internal signals:
  - take = Branch_EX & Zero_EX.
  - hz = MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (UsesRt_ID & (Rt_EX == Rt_ID))).
- States: RUN, STALL, FLUSH. A 2-bit down-counter cnt is shared by STALL and FLUSH.
- Reset (Rst_n low, asynchronous):
  - state = RUN, cnt = 0, both counters = 0.
  - While Rst_n is low, outputs are forced to PCWrite = 0, IFIDWrite = 0, IFIDFlush = 1, IDEXFlush = 1, PCSrc = 0.
  - Outputs take normal values in the first cycle after deassertion.
- RUN, priority take > Jump_ID > hz. All outputs in RUN are combinational in the same cycle.
  - take: PCSrc = 1, PCWrite = 1, IFIDFlush = 1, IDEXFlush = 1. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1; otherwise stay in RUN. FlushCount increments.
  - Jump_ID (no take): PCSrc = 2, PCWrite = 1, IFIDFlush = 1, IDEXFlush = 0. Stay in RUN. FlushCount increments.
  - hz (no take, no jump): PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1. Go to STALL with cnt = STALL_CYCLES-1 if STALL_CYCLES > 1; otherwise stay in RUN. StallCount increments.
  - None of the above: PCWrite = 1, IFIDWrite = 1, no flushes, PCSrc = 0.
- STALL:
  - PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1, PCSrc = 0.
  - cnt decrements each cycle; return to RUN after the cycle in which cnt == 0.
  - take or Jump_ID is ignored here: ID/EX holds bubbles, so neither can be valid.
- FLUSH:
  - IFIDFlush = 1, IDEXFlush = 1, PCWrite = 1, IFIDWrite = 1, PCSrc = 0.
  - cnt decrements each cycle; return to RUN after cnt == 0.
  - take, Jump_ID and hz are ignored (wrong-path instructions).
- Hazard detail:
  - Rt_EX == 0 never produces a hazard.
  - A back-to-back hazard after STALL exits is re-evaluated normally in RUN.
- Counters:
  - Increment by 1 per qualifying RUN-state event.
  - Saturate at all-ones; no wrap.
  - Updates are registered, so the new value is visible the cycle after the event.
- Reset asserted mid-STALL or mid-FLUSH aborts immediately to the reset values above.

Decomposition:
- Shared package holds:
  - state encoding constants: RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2.
  - PCSrc encodings: PCSRC_SEQ = 0, PCSRC_BR = 1, PCSRC_JMP = 2.
- One sub-module, sat_counter (parameter W; inputs Clk, Rst_n, Inc; output Count), instantiated twice.

Test Plan:
- Reset: Rst_n low for 3 cycles with random inputs -> PCWrite = 0, IFIDFlush = 1, IDEXFlush = 1, counters = 0. Release -> PCWrite = 1, PCSrc = 0 next cycle.
- Load-use hazard, defaults: MemRead_EX = 1, Rt_EX = 8, Rs_ID = 8 for 1 cycle -> that cycle PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1; back to RUN next cycle; StallCount = 1. Repeat with Rt_EX = 0 -> no stall.
- Taken branch, FLUSH_CYCLES = 2: Branch_EX = 1, Zero_EX = 1 -> PCSrc = 1 and both flushes high that cycle, flushes high 1 more cycle, then RUN; FlushCount = 1. With Zero_EX = 0 -> no action.
- Simultaneous events: take = 1, Jump_ID = 1, hz = 1 in one cycle -> PCSrc = 1, StallCount unchanged, FlushCount +1. Jump_ID + hz only -> PCSrc = 2, no stall.
- STALL_CYCLES = 3: one hazard -> PCWrite low exactly 3 cycles. take asserted during cycle 2 -> ignored, PCSrc stays 0.
- Saturation and abort: CNT_W = 4, issue 20 hazards -> StallCount = 15. Assert Rst_n low mid-FLUSH -> immediate reset outputs, state RUN after release.

Source files
------------

// File: rtl/hazard_branch_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/branch sequencing controller.
package hazard_branch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrlState_t;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  localparam logic [W-1:0] ONE = W'(1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Count <= '0;
    end else if (Inc && (Count != '1)) begin
      Count <= Count + ONE;
    end
  end

endmodule

// File: rtl/hazard_branch_ctrl.sv
// Load-use stall, taken-branch/jump redirect and wrong-path flush sequencing
// for the 5-stage pipeline, with saturating stall/flush event counters.
module hazard_branch_ctrl
  import hazard_branch_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Branch_EX,
  input  logic             Zero_EX,
  input  logic             Jump_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       Rt_EX,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRt_ID,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic [1:0]       PCSrc,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] STALL_INIT = 2'(STALL_CYCLES - 1);
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  ctrlState_t state, stateNext;
  logic [1:0] cnt, cntNext;
  logic       take, hz, stallEvt, flushEvt;

  assign take = Branch_EX & Zero_EX;
  assign hz   = MemRead_EX & (Rt_EX != 5'd0) &
                ((Rt_EX == Rs_ID) | (UsesRt_ID & (Rt_EX == Rt_ID)));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    PCSrc     = PCSRC_SEQ;
    stallEvt  = 1'b0;
    flushEvt  = 1'b0;

    unique case (state)
      RUN: begin
        if (take) begin
          PCSrc     = PCSRC_BR;
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
          flushEvt  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            stateNext = FLUSH;
            cntNext   = FLUSH_INIT;
          end
        end else if (Jump_ID) begin
          PCSrc     = PCSRC_JMP;
          IFIDFlush = 1'b1;
          flushEvt  = 1'b1;
        end else if (hz) begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
          stallEvt  = 1'b1;
          if (STALL_CYCLES > 1) begin
            stateNext = STALL;
            cntNext   = STALL_INIT;
          end
        end
      end
      // The cnt value loaded on entry equals the number of cycles spent here.
      STALL: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b1;
        cntNext   = cnt - 2'd1;
        if (cnt <= 2'd1) stateNext = RUN;
      end
      FLUSH: begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        cntNext   = cnt - 2'd1;
        if (cnt <= 2'd1) stateNext = RUN;
      end
      default: begin
        stateNext = RUN;
        cntNext   = 2'd0;
      end
    endcase

    // Reset overrides everything combinationally so the pipeline is frozen and flushed.
    if (!Rst_n) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      PCSrc     = PCSRC_SEQ;
      stallEvt  = 1'b0;
      flushEvt  = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Inc   (stallEvt),
    .Count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Inc   (flushEvt),
    .Count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_branch_ctrl.sv
// Directed bench: dutA uses default parameters, dutB uses STALL_CYCLES=3, CNT_W=4.
module tb_hazard_branch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        Branch_EX, Zero_EX, Jump_ID, MemRead_EX, UsesRt_ID;
  logic [4:0]  Rt_EX, Rs_ID, Rt_ID;

  logic        pcWriteA, ifidWriteA, ifidFlushA, idexFlushA;
  logic [1:0]  pcSrcA;
  logic [15:0] stallCntA, flushCntA;
  logic        pcWriteB, ifidWriteB, ifidFlushB, idexFlushB;
  logic [1:0]  pcSrcB;
  logic [3:0]  stallCntB, flushCntB;

  int nChecks = 0;
  int nPass   = 0;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PCSrc}
  localparam logic [5:0] RST = 6'b001100;
  localparam logic [5:0] SEQ = 6'b110000;
  localparam logic [5:0] STL = 6'b000100;
  localparam logic [5:0] BR  = 6'b111101;
  localparam logic [5:0] JMP = 6'b111010;
  localparam logic [5:0] FLS = 6'b111100;

  always #5 Clk = ~Clk;

  hazard_branch_ctrl dutA (
    .Clk(Clk), .Rst_n(Rst_n), .Branch_EX(Branch_EX), .Zero_EX(Zero_EX),
    .Jump_ID(Jump_ID), .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Rs_ID(Rs_ID),
    .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID), .PCWrite(pcWriteA), .IFIDWrite(ifidWriteA),
    .IFIDFlush(ifidFlushA), .IDEXFlush(idexFlushA), .PCSrc(pcSrcA),
    .StallCount(stallCntA), .FlushCount(flushCntA)
  );

  hazard_branch_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dutB (
    .Clk(Clk), .Rst_n(Rst_n), .Branch_EX(Branch_EX), .Zero_EX(Zero_EX),
    .Jump_ID(Jump_ID), .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Rs_ID(Rs_ID),
    .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID), .PCWrite(pcWriteB), .IFIDWrite(ifidWriteB),
    .IFIDFlush(ifidFlushB), .IDEXFlush(idexFlushB), .PCSrc(pcSrcB),
    .StallCount(stallCntB), .FlushCount(flushCntB)
  );

  function automatic logic [5:0] ctlA();
    return {pcWriteA, ifidWriteA, ifidFlushA, idexFlushA, pcSrcA};
  endfunction

  function automatic logic [5:0] ctlB();
    return {pcWriteB, ifidWriteB, ifidFlushB, idexFlushB, pcSrcB};
  endfunction

  task automatic clear();
    Branch_EX = 0; Zero_EX = 0; Jump_ID = 0; MemRead_EX = 0; UsesRt_ID = 0;
    Rt_EX = 0; Rs_ID = 0; Rt_ID = 0;
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic setHz(input logic [4:0] r);
    MemRead_EX = 1; Rt_EX = r; Rs_ID = r;
  endtask

  task automatic do_reset();
    step(); clear(); Rst_n = 0;
    step(); Rst_n = 1; #1;
  endtask

  task automatic test_reset();
    clear();
    #2 Rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      Branch_EX = 1'($urandom); Zero_EX = 1'($urandom); Jump_ID = 1'($urandom);
      MemRead_EX = 1'($urandom); UsesRt_ID = 1'($urandom);
      Rt_EX = 5'($urandom); Rs_ID = 5'($urandom); Rt_ID = 5'($urandom);
      #1;
      nChecks++; if (ctlA() !== RST) $display("FAIL reset_ctl_a cyc%0d: got %b want %b", i, ctlA(), RST); else nPass++;
      nChecks++; if (ctlB() !== RST) $display("FAIL reset_ctl_b cyc%0d: got %b want %b", i, ctlB(), RST); else nPass++;
    end
    nChecks++; if (stallCntA !== 16'd0 || flushCntA !== 16'd0)
      $display("FAIL reset_counts: stall=%0d flush=%0d want 0/0", stallCntA, flushCntA); else nPass++;
    step(); clear(); Rst_n = 1; #1;
    nChecks++; if (ctlA() !== SEQ) $display("FAIL reset_release: got %b want %b", ctlA(), SEQ); else nPass++;
    step();
    nChecks++; if (ctlA() !== SEQ) $display("FAIL reset_release_next: got %b want %b", ctlA(), SEQ); else nPass++;
  endtask

  task automatic test_load_use();
    do_reset();
    setHz(5'd8); #1;
    nChecks++; if (ctlA() !== STL) $display("FAIL lu_stall: got %b want %b", ctlA(), STL); else nPass++;
    step(); clear(); #1;
    nChecks++; if (ctlA() !== SEQ) $display("FAIL lu_resume: got %b want %b", ctlA(), SEQ); else nPass++;
    nChecks++; if (stallCntA !== 16'd1) $display("FAIL lu_count: got %0d want 1", stallCntA); else nPass++;
    setHz(5'd0); #1;
    nChecks++; if (ctlA() !== SEQ) $display("FAIL lu_rt0: got %b want %b", ctlA(), SEQ); else nPass++;
    step(); clear();
    // Rt match only counts when the ID instruction actually reads Rt.
    MemRead_EX = 1; Rt_EX = 5'd9; Rs_ID = 5'd3; Rt_ID = 5'd9; UsesRt_ID = 0; #1;
    nChecks++; if (ctlA() !== SEQ) $display("FAIL lu_rt_unused: got %b want %b", ctlA(), SEQ); else nPass++;
    UsesRt_ID = 1; #1;
    nChecks++; if (ctlA() !== STL) $display("FAIL lu_rt_used: got %b want %b", ctlA(), STL); else nPass++;
    step(); clear(); #1;
    nChecks++; if (stallCntA !== 16'd2) $display("FAIL lu_count2: got %0d want 2", stallCntA); else nPass++;
  endtask

  task automatic test_branch();
    do_reset();
    Branch_EX = 1; Zero_EX = 1; #1;
    nChecks++; if (ctlA() !== BR) $display("FAIL br_take: got %b want %b", ctlA(), BR); else nPass++;
    step(); clear(); #1;
    nChecks++; if (ctlA() !== FLS) $display("FAIL br_flush2: got %b want %b", ctlA(), FLS); else nPass++;
    nChecks++; if (flushCntA !== 16'd1) $display("FAIL br_count: got %0d want 1", flushCntA); else nPass++;
    step();
    nChecks++; if (ctlA() !== SEQ) $display("FAIL br_run: got %b want %b", ctlA(), SEQ); else nPass++;
    Branch_EX = 1; Zero_EX = 0; #1;
    nChecks++; if (ctlA() !== SEQ) $display("FAIL br_not_taken: got %b want %b", ctlA(), SEQ); else nPass++;
    step(); clear(); #1;
    nChecks++; if (flushCntA !== 16'd1) $display("FAIL br_nt_count: got %0d want 1", flushCntA); else nPass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    Branch_EX = 1; Zero_EX = 1; Jump_ID = 1; setHz(5'd5); #1;
    nChecks++; if (ctlA() !== BR) $display("FAIL sim_all: got %b want %b", ctlA(), BR); else nPass++;
    step(); #1;
    nChecks++; if (ctlA() !== FLS) $display("FAIL sim_flush_ignores: got %b want %b", ctlA(), FLS); else nPass++;
    nChecks++; if (stallCntA !== 16'd0 || flushCntA !== 16'd1)
      $display("FAIL sim_counts: stall=%0d flush=%0d want 0/1", stallCntA, flushCntA); else nPass++;
    step(); clear(); #1;
    nChecks++; if (stallCntA !== 16'd0 || flushCntA !== 16'd1)
      $display("FAIL sim_flush_counts: stall=%0d flush=%0d want 0/1", stallCntA, flushCntA); else nPass++;
    Jump_ID = 1; setHz(5'd5); #1;
    nChecks++; if (ctlA() !== JMP) $display("FAIL sim_jump_hz: got %b want %b", ctlA(), JMP); else nPass++;
    step(); clear(); #1;
    nChecks++; if (stallCntA !== 16'd0 || flushCntA !== 16'd2)
      $display("FAIL sim_jump_counts: stall=%0d flush=%0d want 0/2", stallCntA, flushCntA); else nPass++;
    nChecks++; if (ctlA() !== SEQ) $display("FAIL sim_jump_run: got %b want %b", ctlA(), SEQ); else nPass++;
  endtask

  task automatic test_stall3();
    do_reset();
    setHz(5'd12); #1;
    nChecks++; if (ctlB() !== STL) $display("FAIL s3_cyc1: got %b want %b", ctlB(), STL); else nPass++;
    step(); clear(); Branch_EX = 1; Zero_EX = 1; #1;
    nChecks++; if (ctlB() !== STL) $display("FAIL s3_cyc2_take_ignored: got %b want %b", ctlB(), STL); else nPass++;
    step(); clear(); #1;
    nChecks++; if (ctlB() !== STL) $display("FAIL s3_cyc3: got %b want %b", ctlB(), STL); else nPass++;
    nChecks++; if (flushCntB !== 4'd0) $display("FAIL s3_take_count: got %0d want 0", flushCntB); else nPass++;
    step();
    nChecks++; if (ctlB() !== SEQ) $display("FAIL s3_cyc4_run: got %b want %b", ctlB(), SEQ); else nPass++;
    step(); setHz(5'd12); #1;
    nChecks++; if (ctlB() !== STL) $display("FAIL s3_back_to_back: got %b want %b", ctlB(), STL); else nPass++;
    step(); clear(); #1;
    nChecks++; if (stallCntB !== 4'd2) $display("FAIL s3_count: got %0d want 2", stallCntB); else nPass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      setHz(5'd7);
      step(); clear();
      step(); step();
    end
    #1;
    nChecks++; if (stallCntB !== 4'd15) $display("FAIL sat_b: got %0d want 15", stallCntB); else nPass++;
    nChecks++; if (stallCntA !== 16'd20) $display("FAIL sat_a_nosat: got %0d want 20", stallCntA); else nPass++;
  endtask

  task automatic test_abort();
    do_reset();
    Branch_EX = 1; Zero_EX = 1;
    step(); clear(); #1;
    nChecks++; if (ctlA() !== FLS) $display("FAIL ab_in_flush: got %b want %b", ctlA(), FLS); else nPass++;
    Rst_n = 0; #1;
    nChecks++; if (ctlA() !== RST) $display("FAIL ab_reset_now: got %b want %b", ctlA(), RST); else nPass++;
    nChecks++; if (flushCntA !== 16'd0) $display("FAIL ab_count_clr: got %0d want 0", flushCntA); else nPass++;
    step(); Rst_n = 1; #1;
    nChecks++; if (ctlA() !== SEQ) $display("FAIL ab_run_a: got %b want %b", ctlA(), SEQ); else nPass++;
    nChecks++; if (ctlB() !== SEQ) $display("FAIL ab_run_b: got %b want %b", ctlB(), SEQ); else nPass++;
  endtask

  initial begin
    clear();
    test_reset();
    test_load_use();
    test_branch();
    test_simultaneous();
    test_stall3();
    test_saturation();
    test_abort();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
